// File: rtl/midi_rx_parser.sv
// MIDI UART receiver plus channel-voice parser driving a monophonic, last-note-priority note interface.
// Byte deframing is 16x+ oversampled with mid-bit sampling; note outputs are registered one cycle after the completing byte.
module midi_rx_parser #(
    parameter int CLK_HZ  = 25000000,
    parameter int BAUD    = 31250,
    parameter int CHANNEL = 0,
    parameter int OMNI    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       midi_rx,
    output logic [7:0] midi_data,
    output logic       midi_valid,
    output logic [6:0] velocity,
    output logic       note_strobe,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       framing_error
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    CH        = 4'(CHANNEL);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [1:0] {
        P_NONE, P_KEY, P_VEL
    } p_state_t;

    logic            r_rx_s1;
    logic            r_rx_s2;
    logic            r_rx_prev;
    rx_state_t       r_rx_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [7:0]      r_rx_byte;
    logic            r_rx_byte_valid;
    logic            r_framing_error;

    p_state_t        r_p_state;
    logic [7:0]      r_run_status;
    logic [6:0]      r_key;
    logic [7:0]      r_midi_data;
    logic            r_midi_valid;
    logic [6:0]      r_velocity;
    logic            r_note_strobe;

    logic            w_rx;
    logic            w_start_edge;
    logic            w_is_realtime;
    logic            w_is_system;
    logic            w_byte_note_status;
    logic            w_run_note_on;

    assign w_rx         = r_rx_s2;
    assign w_start_edge = r_rx_prev & ~w_rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= midi_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state      <= RX_IDLE;
            r_cnt           <= '0;
            r_bit           <= '0;
            r_shift         <= '0;
            r_rx_byte       <= '0;
            r_rx_byte_valid <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_rx_byte_valid <= 1'b0;
            r_framing_error <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                    if (w_start_edge) r_rx_state <= RX_START;
                end
                RX_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt      <= '0;
                        r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            r_rx_byte       <= r_shift;
                            r_rx_byte_valid <= 1'b1;
                            r_rx_state      <= RX_IDLE;
                        end else begin
                            r_framing_error <= 1'b1;
                            r_rx_state      <= RX_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (w_rx) r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign w_is_realtime      = (r_rx_byte[7:3] == 5'b11111);
    assign w_is_system        = (r_rx_byte[7:4] == 4'hF);
    assign w_byte_note_status = (r_rx_byte[7:5] == 3'b100) &&
                                ((OMNI != 0) || (r_rx_byte[3:0] == CH));
    // Channel is rechecked here so the executed message always agrees with the latched status.
    assign w_run_note_on      = (r_run_status[7:4] == 4'h9) &&
                                ((OMNI != 0) || (r_run_status[3:0] == CH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_state     <= P_NONE;
            r_run_status  <= '0;
            r_key         <= '0;
            r_midi_data   <= '0;
            r_midi_valid  <= 1'b0;
            r_velocity    <= '0;
            r_note_strobe <= 1'b0;
        end else begin
            r_note_strobe <= 1'b0;
            if (r_rx_byte_valid) begin
                if (r_rx_byte[7]) begin
                    if (!w_is_realtime) begin
                        if (w_is_system) begin
                            r_run_status <= '0;
                            r_p_state    <= P_NONE;
                        end else begin
                            r_run_status <= r_rx_byte;
                            r_p_state    <= w_byte_note_status ? P_KEY : P_NONE;
                        end
                    end
                end else begin
                    case (r_p_state)
                        P_KEY: begin
                            r_key     <= r_rx_byte[6:0];
                            r_p_state <= P_VEL;
                        end
                        P_VEL: begin
                            r_p_state <= P_KEY;
                            if (w_run_note_on && (r_rx_byte[6:0] != 7'd0)) begin
                                r_midi_data   <= {1'b0, r_key};
                                r_velocity    <= r_rx_byte[6:0];
                                r_midi_valid  <= 1'b1;
                                r_note_strobe <= 1'b1;
                            end else if (r_midi_valid && (r_key == r_midi_data[6:0])) begin
                                r_midi_valid  <= 1'b0;
                                r_note_strobe <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign midi_data     = r_midi_data;
    assign midi_valid    = r_midi_valid;
    assign velocity      = r_velocity;
    assign note_strobe   = r_note_strobe;
    assign rx_byte       = r_rx_byte;
    assign rx_byte_valid = r_rx_byte_valid;
    assign framing_error = r_framing_error;

endmodule

// File: tb/tb_midi_rx_parser.sv
// Directed bench for midi_rx_parser at 100 clocks per bit; a second OMNI instance shares the line.
module tb_midi_rx_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       midi_rx = 1'b1;

    logic [7:0] midi_data, o_midi_data;
    logic       midi_valid, o_midi_valid;
    logic [6:0] velocity, o_velocity;
    logic       note_strobe, o_note_strobe;
    logic [7:0] rx_byte, o_rx_byte;
    logic       rx_byte_valid, o_rx_byte_valid;
    logic       framing_error, o_framing_error;

    int total = 0;
    int bad   = 0;
    int n_strobe = 0;
    int n_rxv    = 0;
    int n_fe     = 0;

    midi_rx_parser #(.CLK_HZ(3125000), .BAUD(31250), .CHANNEL(0), .OMNI(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .midi_rx(midi_rx),
        .midi_data(midi_data), .midi_valid(midi_valid), .velocity(velocity),
        .note_strobe(note_strobe), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
        .framing_error(framing_error)
    );

    midi_rx_parser #(.CLK_HZ(3125000), .BAUD(31250), .CHANNEL(0), .OMNI(1)) u_omni (
        .clk(clk), .rst_n(rst_n), .midi_rx(midi_rx),
        .midi_data(o_midi_data), .midi_valid(o_midi_valid), .velocity(o_velocity),
        .note_strobe(o_note_strobe), .rx_byte(o_rx_byte), .rx_byte_valid(o_rx_byte_valid),
        .framing_error(o_framing_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (note_strobe)   n_strobe++;
        if (rx_byte_valid) n_rxv++;
        if (framing_error) n_fe++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int cpb);
        logic [7:0] v;
        v = b;
        @(negedge clk);
        midi_rx = 1'b0;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            midi_rx = v[i];
            repeat (cpb) @(negedge clk);
        end
        midi_rx = stop_val;
        repeat (cpb) @(negedge clk);
        midi_rx = 1'b1;
        if (!stop_val) repeat (cpb) @(negedge clk);
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a, 1'b1, 100);
        send_byte(b, 1'b1, 100);
        send_byte(c, 1'b1, 100);
    endtask

    task automatic test_reset;
        repeat (5) @(negedge clk);
        total++; if (midi_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", midi_data); end
        total++; if (midi_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", midi_valid); end
        total++; if (velocity !== 7'h00) begin bad++; $display("FAIL reset_vel got=%h want=00", velocity); end
        total++; if (rx_byte !== 8'h00) begin bad++; $display("FAIL reset_rx_byte got=%h want=00", rx_byte); end
        total++; if ({note_strobe, rx_byte_valid, framing_error} !== 3'b000)
            begin bad++; $display("FAIL reset_pulses got=%b want=000", {note_strobe, rx_byte_valid, framing_error}); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_basic_note_on;
        int s0, r0;
        s0 = n_strobe; r0 = n_rxv;
        send3(8'h90, 8'h45, 8'h64);
        total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL basic_strobes got=%0d want=1", n_strobe - s0); end
        total++; if (n_rxv - r0 !== 3) begin bad++; $display("FAIL basic_rxv got=%0d want=3", n_rxv - r0); end
        total++; if (midi_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", midi_valid); end
        total++; if (midi_data !== 8'h45) begin bad++; $display("FAIL basic_data got=%h want=45", midi_data); end
        total++; if (velocity !== 7'h64) begin bad++; $display("FAIL basic_vel got=%h want=64", velocity); end
        total++; if (rx_byte !== 8'h64) begin bad++; $display("FAIL basic_rx_byte got=%h want=64", rx_byte); end
    endtask

    task automatic test_running_status;
        int s0;
        s0 = n_strobe;
        send_byte(8'h48, 1'b1, 100);
        send_byte(8'h50, 1'b1, 100);
        total++; if (midi_data !== 8'h48) begin bad++; $display("FAIL rs_on_data got=%h want=48", midi_data); end
        total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL rs_on_strobe got=%0d want=1", n_strobe - s0); end
        s0 = n_strobe;
        send_byte(8'h45, 1'b1, 100);
        send_byte(8'h00, 1'b1, 100);
        total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL rs_other_off_strobe got=%0d want=0", n_strobe - s0); end
        total++; if (midi_valid !== 1'b1) begin bad++; $display("FAIL rs_other_off_valid got=%b want=1", midi_valid); end
        s0 = n_strobe;
        send_byte(8'h48, 1'b1, 100);
        send_byte(8'h00, 1'b1, 100);
        total++; if (midi_valid !== 1'b0) begin bad++; $display("FAIL rs_off_valid got=%b want=0", midi_valid); end
        total++; if (midi_data !== 8'h48) begin bad++; $display("FAIL rs_off_data got=%h want=48", midi_data); end
        total++; if (velocity !== 7'h50) begin bad++; $display("FAIL rs_off_vel got=%h want=50", velocity); end
        total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL rs_off_strobe got=%0d want=1", n_strobe - s0); end
        s0 = n_strobe;
        send3(8'h80, 8'h48, 8'h10);
        total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL rs_idle_off_strobe got=%0d want=0", n_strobe - s0); end
    endtask

    task automatic test_channel_filter;
        int s0;
        s0 = n_strobe;
        send3(8'h91, 8'h40, 8'h40);
        total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL ch_strobe got=%0d want=0", n_strobe - s0); end
        total++; if (midi_valid !== 1'b0) begin bad++; $display("FAIL ch_valid got=%b want=0", midi_valid); end
        total++; if (o_midi_data !== 8'h40) begin bad++; $display("FAIL omni_data got=%h want=40", o_midi_data); end
        total++; if (o_midi_valid !== 1'b1) begin bad++; $display("FAIL omni_valid got=%b want=1", o_midi_valid); end
    endtask

    task automatic test_realtime_system;
        int s0;
        send_byte(8'h90, 1'b1, 100);
        send_byte(8'h3C, 1'b1, 100);
        send_byte(8'hF8, 1'b1, 100);
        send_byte(8'h7F, 1'b1, 100);
        total++; if (midi_data !== 8'h3C) begin bad++; $display("FAIL rt_data got=%h want=3c", midi_data); end
        total++; if (velocity !== 7'h7F) begin bad++; $display("FAIL rt_vel got=%h want=7f", velocity); end
        total++; if (midi_valid !== 1'b1) begin bad++; $display("FAIL rt_valid got=%b want=1", midi_valid); end
        s0 = n_strobe;
        send_byte(8'h3C, 1'b1, 100);
        send_byte(8'h20, 1'b1, 100);
        total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL retrig_strobe got=%0d want=1", n_strobe - s0); end
        total++; if (velocity !== 7'h20) begin bad++; $display("FAIL retrig_vel got=%h want=20", velocity); end
        s0 = n_strobe;
        send3(8'hF2, 8'h3E, 8'h40);
        total++; if (midi_data !== 8'h3C) begin bad++; $display("FAIL sys_data got=%h want=3c", midi_data); end
        total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL sys_strobe got=%0d want=0", n_strobe - s0); end
    endtask

    task automatic test_line_errors;
        int s0, r0, f0;
        s0 = n_strobe; r0 = n_rxv; f0 = n_fe;
        send_byte(8'h90, 1'b0, 100);
        total++; if (n_fe - f0 !== 1) begin bad++; $display("FAIL fe_pulse got=%0d want=1", n_fe - f0); end
        total++; if (n_rxv - r0 !== 0) begin bad++; $display("FAIL fe_rxv got=%0d want=0", n_rxv - r0); end
        // a discarded 0x90 must not arm the parser: this would otherwise release note 0x3C
        send_byte(8'h3C, 1'b1, 100);
        send_byte(8'h00, 1'b1, 100);
        total++; if (midi_valid !== 1'b1) begin bad++; $display("FAIL fe_parser_valid got=%b want=1", midi_valid); end
        total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL fe_parser_strobe got=%0d want=0", n_strobe - s0); end
        r0 = n_rxv; f0 = n_fe;
        @(negedge clk);
        midi_rx = 1'b0;
        repeat (30) @(negedge clk);
        midi_rx = 1'b1;
        repeat (300) @(negedge clk);
        total++; if (n_rxv - r0 !== 0) begin bad++; $display("FAIL glitch_rxv got=%0d want=0", n_rxv - r0); end
        total++; if (n_fe - f0 !== 0) begin bad++; $display("FAIL glitch_fe got=%0d want=0", n_fe - f0); end
    endtask

    task automatic test_baud_tolerance;
        send_byte(8'h90, 1'b1, 102);
        send_byte(8'h50, 1'b1, 102);
        send_byte(8'h33, 1'b1, 102);
        total++; if (midi_data !== 8'h50) begin bad++; $display("FAIL slow_data got=%h want=50", midi_data); end
        total++; if (velocity !== 7'h33) begin bad++; $display("FAIL slow_vel got=%h want=33", velocity); end
        send_byte(8'h51, 1'b1, 98);
        send_byte(8'h34, 1'b1, 98);
        total++; if (midi_data !== 8'h51) begin bad++; $display("FAIL fast_data got=%h want=51", midi_data); end
        total++; if (velocity !== 7'h34) begin bad++; $display("FAIL fast_vel got=%h want=34", velocity); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] v;
        v = 8'h55;
        send_byte(8'h90, 1'b1, 100);
        send_byte(8'h45, 1'b1, 100);
        @(negedge clk);
        midi_rx = 1'b0;
        repeat (100) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            midi_rx = v[i];
            repeat (100) @(negedge clk);
        end
        midi_rx = v[4];
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({midi_data, midi_valid, velocity, rx_byte} !== 24'h0)
            begin bad++; $display("FAIL midrst_outputs got=%h/%b/%h/%h want=0", midi_data, midi_valid, velocity, rx_byte); end
        total++; if ({note_strobe, rx_byte_valid, framing_error} !== 3'b000)
            begin bad++; $display("FAIL midrst_pulses got=%b want=000", {note_strobe, rx_byte_valid, framing_error}); end
        midi_rx = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send3(8'h90, 8'h30, 8'h20);
        total++; if (midi_data !== 8'h30) begin bad++; $display("FAIL postrst_data got=%h want=30", midi_data); end
        total++; if (midi_valid !== 1'b1) begin bad++; $display("FAIL postrst_valid got=%b want=1", midi_valid); end
        total++; if (velocity !== 7'h20) begin bad++; $display("FAIL postrst_vel got=%h want=20", velocity); end
    endtask

    initial begin
        test_reset;
        test_basic_note_on;
        test_running_status;
        test_channel_filter;
        test_realtime_system;
        test_line_errors;
        test_baud_tolerance;
        test_reset_mid_frame;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/midi_rx_parser.md
# midi_rx_parser

Serial MIDI front end that produces the `midi_data`/`midi_valid` note stream consumed by the tone-generator player. It receives a 31250-baud MIDI UART line, deframes bytes, and parses channel-voice messages with running status. It drives a monophonic last-note-priority interface: the current note number plus a level that stays high while that note is held.

## Interface
- `CLK_HZ`, 25000000, system clock frequency.
- `BAUD`, 31250, serial bit rate; `CLKS_PER_BIT = CLK_HZ/BAUD` (integer, ≥16).
- `CHANNEL`, 0, MIDI channel 0-15 accepted.
- `OMNI`, 0, 1 = accept note messages on all channels.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `midi_rx`  in  1  asynchronous serial MIDI line, idle high.
- `midi_data`  out  8  current note number, bit 7 always 0.
- `midi_valid`  out  1  high while `midi_data` is a held note.
- `velocity`  out  7  velocity of the last accepted Note On.
- `note_strobe`  out  1  one-cycle pulse on any `midi_data`/`midi_valid` update.
- `rx_byte`  out  8  last deframed byte (debug).
- `rx_byte_valid`  out  1  one-cycle pulse per good byte.
- `framing_error`  out  1  one-cycle pulse on bad stop bit.

## Operation
- Clock domain and reset: one clock domain, `clk`; reset is asynchronous and active-low on `rst_n`.
- Input synchronisation: `midi_rx` passes through a 2-flop synchronizer, reset to 1. All decoding uses the synchronized signal.
- Receiver FSM:
  - IDLE: a 1→0 transition enters START with bit counter cleared.
  - START: sample at `CLKS_PER_BIT/2`. If low, go to DATA. If high, it is a glitch: return to IDLE, no byte.
  - DATA: 8 samples, one every `CLKS_PER_BIT`, LSB first.
  - STOP: sample after a further `CLKS_PER_BIT`. If high, pulse `rx_byte_valid` and update `rx_byte`, then go to IDLE. If low, pulse `framing_error`, discard the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until the line is high, then go to IDLE.
- Parser (advances only on `rx_byte_valid`). It holds `run_status[7:0]` and a state NONE / KEY / VEL.
  - 0xF8-0xFF (real-time): ignored; no change to state or running status.
  - 0xF0-0xF7 (system common/exclusive): clear running status; go to NONE.
  - 0x80-0xEF: latch running status. Go to KEY if the byte is 0x8n or 0x9n and the channel matches (n == `CHANNEL`, or `OMNI`=1); otherwise go to NONE.
  - Data byte in NONE: ignored.
  - Data byte in KEY: latch the key, go to VEL.
  - Data byte in VEL: execute the message, return to KEY (running status).
- Execute:
  - Note On with velocity > 0: `midi_data`←key, `velocity`←vel, `midi_valid`←1, pulse `note_strobe`.
  - Note Off, or Note On with velocity 0: if `midi_valid` and key == `midi_data`, then `midi_valid`←0 and pulse `note_strobe`; `midi_data` and `velocity` are retained. Otherwise no change.
- Retriggering the same key while held still pulses `note_strobe`.

## Timing
- Reset values: `midi_data`=0, `midi_valid`=0, `velocity`=0, all pulses 0, `rx_byte`=0, receiver in IDLE, parser in NONE, `run_status`=0.
- Reset asserted mid-frame or mid-message aborts everything. The first start edge after release begins a fresh frame; a partial frame in flight is lost.
- The start edge is seen 2 cycles after the pin edge (synchronizer).
- `rx_byte_valid` pulses in the cycle after the stop-bit sample.
- Note outputs and `note_strobe` update in the cycle after `rx_byte_valid` of the completing data byte.
- Back-to-back frames (stop bit followed immediately by a start bit) must be received without loss.
- Baud-counter tolerance: ±2% rate mismatch must decode correctly.
- Outputs are registered. `midi_data` is stable except in the `note_strobe` cycle.

## Test plan
- Basic Note On (`CLK_HZ`=3125000, 100 clk/bit, `CHANNEL`=0): send 0x90 0x45 0x64 → exactly one `note_strobe`, `midi_valid`=1, `midi_data`=0x45, `velocity`=0x64; three `rx_byte_valid` pulses.
- Running status: following 0x48 0x50 → `midi_data`=0x48. Then 0x45 0x00 → no change, no strobe. Then 0x48 0x00 → `midi_valid`=0, `midi_data` stays 0x48. Then 0x80 0x48 0x10 → no strobe.
- Channel filter: 0x91 0x40 0x40 with `CHANNEL`=0 → no strobe. Same sequence with `OMNI`=1 → `midi_data`=0x40, `midi_valid`=1.
- Real-time and system common: 0x90 0x3C 0xF8 0x7F → note 0x3C on, `velocity`=0x7F. Then 0xF2 0x3E 0x40 → ignored, `midi_data` stays 0x3C.
- Line errors: 0x90 with stop bit driven low → `framing_error` pulse, no `rx_byte_valid`, parser unchanged. A 30-cycle low glitch → no byte.
- Reset mid-frame: pull `rst_n` low during bit 4 of a velocity byte → all outputs 0 immediately. After release, 0x90 0x30 0x20 → `midi_data`=0x30, `midi_valid`=1.
